mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the instruction-fetch stage (read-only) and the MEM stage (load/store, atomic read-modify-write).
- Sits between the IF/MEM stages and the memory block.
- Sequences each access through a fixed-latency handshake and returns per-requester ready pulses, which the pipeline uses as stall-release signals.
- Data accesses have priority; a streak limit prevents fetch starvation.

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_port_arbiter_pick.sv | 18 +
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared encodings for the unified memory port arbiter.
// Holds FSM states, access owners and the mem_op_length codes.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_ACCESS  = 2'd1,
        ARB_RESPOND = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_OWNER_IF = 1'b0,
        ARB_OWNER_DM = 1'b1
    } arb_owner_e;

    localparam logic [2:0] MEM_BYTE   = 3'd0;
    localparam logic [2:0] MEM_HALF   = 3'd1;
    localparam logic [2:0] MEM_WORD   = 3'd2;
    localparam logic [2:0] MEM_BYTE_U = 3'd4;
    localparam logic [2:0] MEM_HALF_U = 3'd5;

    localparam int ARB_CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// arb_pick: combinational winner selection for the memory port.
// In: if_req, dm_req, streak_full. Out: grant_valid, grant_owner.
module arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic       if_req,
    input  logic       dm_req,
    input  logic       streak_full,
    output logic       grant_valid,
    output arb_owner_e grant_owner
);

    // Data wins unless fetch has waited through a full data streak.
    assign grant_valid = if_req | dm_req;
    assign grant_owner = (dm_req && !(if_req && streak_full))
                         ? ARB_OWNER_DM : ARB_OWNER_IF;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between IF and MEM.
// Ports: if_* fetch side, dm_* data side, mem_* memory side, busy status.
// Build option ARB_STATS_EN adds saturating grant/conflict counters.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY     = 2,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_address,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_write,
    input  logic [31:0] dm_address,
    input  logic [31:0] dm_wdata,
    input  logic [2:0]  dm_length,
    output logic        dm_ready,
    output logic [31:0] dm_rdata,
    output logic        mem_enable,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_length,
    input  logic [31:0] mem_rdata,
    output logic        busy
`ifdef ARB_STATS_EN
    ,
    output logic [31:0] stat_if_grants,
    output logic [31:0] stat_dm_grants,
    output logic [31:0] stat_conflicts
`endif
);

    arb_state_e           state_q, state_d;
    arb_owner_e           owner_q, grant_owner;
    logic                 grant_valid;
    logic                 grant_fire;
    logic                 access_done;
    logic                 streak_full;
    logic [ARB_CNT_W-1:0] lat_q;
    logic [ARB_CNT_W-1:0] streak_q;

    assign streak_full = (streak_q == ARB_CNT_W'(MAX_DATA_STREAK));
    assign busy        = (state_q != ARB_IDLE);

    arb_pick u_pick (
        .if_req      (if_req),
        .dm_req      (dm_req),
        .streak_full (streak_full),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ARB_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        grant_fire  = 1'b0;
        access_done = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (grant_valid) begin
                    grant_fire = 1'b1;
                    state_d    = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                // lat_q == 1 means this decrement reaches zero.
                if (lat_q == ARB_CNT_W'(1)) begin
                    access_done = 1'b1;
                    state_d     = ARB_RESPOND;
                end
            end
            ARB_RESPOND: state_d = ARB_IDLE;
            default:     state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            owner_q     <= ARB_OWNER_IF;
            lat_q       <= '0;
            streak_q    <= '0;
            mem_enable  <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            mem_length  <= '0;
            if_ready    <= 1'b0;
            dm_ready    <= 1'b0;
            if_rdata    <= '0;
            dm_rdata    <= '0;
        end else begin
            mem_enable <= grant_fire;
            if_ready   <= access_done && (owner_q == ARB_OWNER_IF);
            dm_ready   <= access_done && (owner_q == ARB_OWNER_DM);

            if (grant_fire) begin
                owner_q <= grant_owner;
                lat_q   <= ARB_CNT_W'(MEM_LATENCY);
                if (grant_owner == ARB_OWNER_DM) begin
                    mem_address <= dm_address;
                    mem_wdata   <= dm_wdata;
                    mem_length  <= dm_length;
                    mem_write   <= dm_write;
                end else begin
                    mem_address <= if_address;
                    mem_wdata   <= '0;
                    mem_length  <= MEM_WORD;
                    mem_write   <= 1'b0;
                end
            end else if (state_q == ARB_ACCESS) begin
                lat_q <= lat_q - ARB_CNT_W'(1);
            end

            // Stores leave dm_rdata holding the last load result.
            if (access_done) begin
                if (owner_q == ARB_OWNER_IF) if_rdata <= mem_rdata;
                else if (!mem_write)         dm_rdata <= mem_rdata;
            end

            if (!if_req) begin
                streak_q <= '0;
            end else if (grant_fire) begin
                if (grant_owner == ARB_OWNER_IF) streak_q <= '0;
                else if (!streak_full)           streak_q <= streak_q + ARB_CNT_W'(1);
            end
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_if_grants <= '0;
            stat_dm_grants <= '0;
            stat_conflicts <= '0;
        end else begin
            if (if_req && dm_req && stat_conflicts != '1)
                stat_conflicts <= stat_conflicts + 32'd1;
            if (grant_fire && grant_owner == ARB_OWNER_IF && stat_if_grants != '1)
                stat_if_grants <= stat_if_grants + 32'd1;
            if (grant_fire && grant_owner == ARB_OWNER_DM && stat_dm_grants != '1)
                stat_dm_grants <= stat_dm_grants + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of mem_port_arbiter
// against a cycle-index transaction model of the port.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int L    = 2;
    localparam int MAXS = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        if_req, if_ready;
    logic [31:0] if_address, if_rdata;
    logic        dm_req, dm_write, dm_ready;
    logic [31:0] dm_address, dm_wdata, dm_rdata;
    logic [2:0]  dm_length;
    logic        mem_enable, mem_write;
    logic [31:0] mem_address, mem_wdata, mem_rdata;
    logic [2:0]  mem_length;
    logic        busy;
`ifdef ARB_STATS_EN
    logic [31:0] stat_if_grants, stat_dm_grants, stat_conflicts;
`endif

    always #5 clock = ~clock;

    mem_port_arbiter #(.MEM_LATENCY(L), .MAX_DATA_STREAK(MAXS)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .if_req      (if_req),
        .if_address  (if_address),
        .if_ready    (if_ready),
        .if_rdata    (if_rdata),
        .dm_req      (dm_req),
        .dm_write    (dm_write),
        .dm_address  (dm_address),
        .dm_wdata    (dm_wdata),
        .dm_length   (dm_length),
        .dm_ready    (dm_ready),
        .dm_rdata    (dm_rdata),
        .mem_enable  (mem_enable),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_length  (mem_length),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
`ifdef ARB_STATS_EN
        ,
        .stat_if_grants (stat_if_grants),
        .stat_dm_grants (stat_dm_grants),
        .stat_conflicts (stat_conflicts)
`endif
    );

    // Memory block: combinational read of the registered address.
    logic [31:0] tb_mem  [256];
    logic [31:0] ref_mem [256];
    logic        mem_load;
    assign mem_rdata = tb_mem[mem_address[9:2]];
    always @(posedge clock) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= ref_mem[i];
        end else if (mem_enable === 1'b1 && mem_write === 1'b1) begin
            tb_mem[mem_address[9:2]] <= mem_wdata;
        end
    end

    int n_tests, n_fail;

    // Model: m_t = cycles since grant (0 = port free).
    int          m_t;
    bit          m_dm, m_wr;
    logic [31:0] m_addr, m_wdata, e_if_rd, e_dm_rd;
    logic [2:0]  m_len;
    int          streak, s_if, s_dm, s_conf;

    // Requesters.
    bit          if_act, dm_act, dm_wr, rand_en, b2b, rst_n_next;
    logic [31:0] if_a, dm_a, dm_wd;
    logic [2:0]  dm_len;
    int          p_if, p_dm;

    // Observations.
    int          n_en, n_if_rdy, n_dm_rdy;
    logic [31:0] last_en_addr;
    bit          last_en_wr;
    bit          grant_log[$];
    bit          exp_order [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_dm = 0; m_wr = 0;
        m_addr = '0; m_wdata = '0; m_len = '0;
        e_if_rd = '0; e_dm_rd = '0;
        streak = 0; s_if = 0; s_dm = 0; s_conf = 0;
    endtask

    // Advance the model across the coming rising edge.
    task automatic model_step();
        bit gnt, gdm;
        gnt = 0;
        gdm = 0;
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (if_req && dm_req) s_conf++;
        if (m_t == 0) begin
            if (if_req || dm_req) begin
                gnt = 1;
                gdm = dm_req && !(if_req && streak >= MAXS);
                m_t = 1;
                m_dm = gdm;
                if (gdm) begin
                    m_addr = dm_address; m_wdata = dm_wdata;
                    m_len = dm_length; m_wr = dm_write;
                    s_dm++;
                    if (dm_write) ref_mem[dm_address[9:2]] = dm_wdata;
                end else begin
                    m_addr = if_address; m_wdata = '0;
                    m_len = MEM_WORD; m_wr = 0;
                    s_if++;
                end
            end
        end else if (m_t == L + 1) begin
            m_t = 0;
        end else begin
            m_t++;
            if (m_t == L + 1) begin
                if (!m_dm)      e_if_rd = ref_mem[m_addr[9:2]];
                else if (!m_wr) e_dm_rd = ref_mem[m_addr[9:2]];
            end
        end
        if (!if_req)          streak = 0;
        else if (gnt && gdm)  streak = (streak < MAXS) ? streak + 1 : streak;
        else if (gnt)         streak = 0;
    endtask

    task automatic compare_cycle();
        chk("busy",       32'(busy),       32'(m_t != 0));
        chk("mem_enable", 32'(mem_enable), 32'(m_t == 1));
        chk("if_ready",   32'(if_ready),   32'(m_t == L + 1 && !m_dm));
        chk("dm_ready",   32'(dm_ready),   32'(m_t == L + 1 && m_dm));
        chk("if_rdata",   if_rdata,        e_if_rd);
        chk("dm_rdata",   dm_rdata,        e_dm_rd);
        chk("mem_address", mem_address,    m_addr);
        chk("mem_wdata",  mem_wdata,       m_wdata);
        chk("mem_length", 32'(mem_length), 32'(m_len));
        chk("mem_write",  32'(mem_write),  32'(m_wr));
`ifdef ARB_STATS_EN
        chk("stat_if_grants", stat_if_grants, 32'(s_if));
        chk("stat_dm_grants", stat_dm_grants, 32'(s_dm));
        chk("stat_conflicts", stat_conflicts, 32'(s_conf));
`endif
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},   32'(busy),        32'd0);
        chk({tag, "_en"},     32'(mem_enable),  32'd0);
        chk({tag, "_wr"},     32'(mem_write),   32'd0);
        chk({tag, "_ifrdy"},  32'(if_ready),    32'd0);
        chk({tag, "_dmrdy"},  32'(dm_ready),    32'd0);
        chk({tag, "_ifrd"},   if_rdata,         32'd0);
        chk({tag, "_dmrd"},   dm_rdata,         32'd0);
        chk({tag, "_addr"},   mem_address,      32'd0);
        chk({tag, "_wdata"},  mem_wdata,        32'd0);
        chk({tag, "_len"},    32'(mem_length),  32'd0);
`ifdef ARB_STATS_EN
        chk({tag, "_sif"},    stat_if_grants,   32'd0);
        chk({tag, "_sdm"},    stat_dm_grants,   32'd0);
        chk({tag, "_sconf"},  stat_conflicts,   32'd0);
`endif
    endtask

    task automatic new_if();
        if_act = 1;
        if_a   = 32'($urandom_range(0, 127)) << 2;
    endtask

    task automatic new_dm();
        dm_act = 1;
        dm_a   = 32'h200 | (32'($urandom_range(0, 127)) << 2);
        dm_wr  = 1'($urandom_range(0, 1));
        dm_wd  = $urandom;
        dm_len = 3'($urandom_range(0, 7));
    endtask

    task automatic update_reqs();
        bit rdy, fl_if, fl_dm;
        rdy   = (m_t == L + 1);
        fl_if = (m_t != 0) && !m_dm;
        fl_dm = (m_t != 0) && m_dm;
        if (if_act && rdy && !m_dm) begin
            if_act = 0;
            if (b2b) new_if();
        end else if (rand_en) begin
            if (if_act && fl_if) begin
                if_a = $urandom;
                if ($urandom_range(0, 19) == 0) if_act = 0;
            end else if (!if_act && !fl_if && $urandom_range(0, 99) < p_if) begin
                new_if();
            end
        end
        if (dm_act && rdy && m_dm) begin
            dm_act = 0;
            if (b2b) new_dm();
        end else if (rand_en) begin
            if (dm_act && fl_dm) begin
                dm_a = $urandom; dm_wd = $urandom;
                dm_wr = ~dm_wr; dm_len = ~dm_len;
                if ($urandom_range(0, 19) == 0) dm_act = 0;
            end else if (!dm_act && !fl_dm && $urandom_range(0, 99) < p_dm) begin
                new_dm();
            end
        end
    endtask

    task automatic drive();
        reset_n    = rst_n_next;
        if_req     = if_act;
        if_address = if_a;
        dm_req     = dm_act;
        dm_write   = dm_wr;
        dm_address = dm_a;
        dm_wdata   = dm_wd;
        dm_length  = dm_len;
    endtask

    task automatic tick();
        @(negedge clock);
        compare_cycle();
        if (mem_enable === 1'b1) begin
            n_en++;
            last_en_addr = mem_address;
            last_en_wr   = mem_write;
            grant_log.push_back(mem_address[9]);
        end
        if (if_ready === 1'b1) n_if_rdy++;
        if (dm_ready === 1'b1) n_dm_rdy++;
        update_reqs();
        drive();
        model_step();
    endtask

    task automatic wait_ready(input bit want_dm, output int lat);
        bit seen;
        lat  = 0;
        seen = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            tick();
            if ((want_dm ? dm_ready : if_ready) === 1'b1) begin
                lat  = k;
                seen = 1;
            end
        end
    endtask

    task automatic wait_enable(output bit seen);
        int start;
        start = n_en;
        seen  = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            if (n_en != start) seen = 1;
        end
    endtask

    initial begin
        int lat;
        bit seen, got_bit;
        n_tests = 0; n_fail = 0;
        n_en = 0; n_if_rdy = 0; n_dm_rdy = 0;
        if_act = 0; dm_act = 0; dm_wr = 0; rand_en = 0; b2b = 0;
        if_a = '0; dm_a = '0; dm_wd = '0; dm_len = '0;
        p_if = 0; p_dm = 0;
        last_en_addr = '0; last_en_wr = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
        ref_mem[16] = 32'h0050_0093;
        mem_load   = 1;
        rst_n_next = 0;
        drive();
        model_reset();

        repeat (3) tick();
        check_all_zero("reset");
        mem_load   = 0;
        rst_n_next = 1;
        tick();

        // Single fetch.
        n_en = 0;
        if_a = 32'h40; if_act = 1;
        wait_ready(0, lat);
        chk("fetch_latency", 32'(lat), 32'(L + 2));
        chk("fetch_en_count", 32'(n_en), 32'd1);
        chk("fetch_en_addr", last_en_addr, 32'h40);
        chk("fetch_data", if_rdata, 32'h0050_0093);
        tick();
        chk("fetch_busy_fall", 32'(busy), 32'd0);

        // Store then load.
        n_if_rdy = 0;
        dm_a = 32'h100; dm_wr = 1; dm_wd = 32'hDEAD_BEEF;
        dm_len = MEM_WORD; dm_act = 1;
        wait_ready(1, lat);
        chk("store_latency", 32'(lat), 32'(L + 2));
        chk("store_mem_write", 32'(last_en_wr), 32'd1);
        dm_wr = 0; dm_act = 1;
        wait_ready(1, lat);
        chk("load_latency", 32'(lat), 32'(L + 2));
        chk("load_data", dm_rdata, 32'hDEAD_BEEF);
        chk("no_if_ready", 32'(n_if_rdy), 32'd0);
        tick();

        // Both held continuously.
        grant_log.delete();
        b2b = 1;
        new_if();
        new_dm();
        repeat (6 * (L + 2) + 2) tick();
        b2b = 0;
        repeat (3 * (L + 2)) tick();
        chk("order_len", 32'(grant_log.size() >= 6), 32'd1);
        for (int i = 0; i < 6; i++) begin
            got_bit = (grant_log.size() > i) ? grant_log[i] : ~exp_order[i];
            chk($sformatf("order_%0d", i), 32'(got_bit), 32'(exp_order[i]));
        end

        // Data request dropped mid-access.
        grant_log.delete();
        n_dm_rdy = 0;
        new_dm();
        wait_enable(seen);
        chk("drop_grant_seen", 32'(seen), 32'd1);
        dm_act = 0;
        new_if();
        repeat (2 * (L + 2) + 2) tick();
        chk("drop_dm_ready", 32'(n_dm_rdy), 32'd1);
        got_bit = (grant_log.size() >= 2) ? grant_log[1] : 1'b1;
        chk("drop_next_is_if", 32'(got_bit), 32'd0);

        // Async reset during ACCESS.
        new_if();
        wait_enable(seen);
        chk("rst_grant_seen", 32'(seen), 32'd1);
        tick();
        #2;
        reset_n = 0;
        rst_n_next = 0;
        #1;
        check_all_zero("rst_mid");
        model_reset();
        repeat (2) tick();
        rst_n_next = 1;
        n_if_rdy = 0;
        wait_ready(0, lat);
        chk("rst_fresh_latency", 32'(lat), 32'(L + 2));
        chk("rst_ready_count", 32'(n_if_rdy), 32'd1);

        // Random traffic.
        rand_en = 1;
        for (int c = 0; c < 1500; c++) begin
            if (c % 100 == 0) begin
                b2b  = 1'($urandom_range(0, 1));
                p_if = $urandom_range(5, 90);
                p_dm = $urandom_range(5, 90);
            end
            tick();
        end
        rand_en = 0;
        b2b = 0;
        repeat (30) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
